lut_neuron_pipe: RTL and testbench

- Parametrised, pipelined successor to the generated fixed-ROM LogicNets neurons.
- Truth table of 2**IN_W entries, OUT_W bits each; loaded at run time through a streaming config port instead of being baked into RTL.
- Inference path uses valid/ready handshakes with one registered output stage.
- Sits in a layer wrapper; layer reprogramming needs no resynthesis.

---
 rtl/lut_neuron_pkg.sv | 7 +
 rtl/lut_table_ram.sv | 21 ++
 rtl/lut_neuron_pipe.sv | 90 +++++++++
 tb/tb_lut_neuron_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// lut_neuron_pkg: shared state encoding and table sizing for lut_neuron_pipe
package lut_neuron_pkg;
   typedef enum logic [1:0] {EMPTY, LOAD, RUN, DRAIN} state_t;
   function automatic int depth_f(input int in_w);
      return 1 << in_w;
   endfunction
endpackage

// File: rtl/lut_table_ram.sv
// lut_table_ram: DEPTH x OUT_W distributed RAM, synchronous write, asynchronous read
module lut_table_ram
   import lut_neuron_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [IN_W-1:0]  waddr,
   input  logic [OUT_W-1:0] wdata,
   input  logic [IN_W-1:0]  raddr,
   output logic [OUT_W-1:0] rdata
);
   localparam int DEPTH = depth_f(IN_W);
   (* ram_style = "distributed", rom_style = "distributed" *)
   logic [OUT_W-1:0] mem_q [DEPTH];
   always_ff @(posedge clk)
      if (we) mem_q[waddr] <= wdata;
   assign rdata = mem_q[raddr];
endmodule

// File: rtl/lut_neuron_pipe.sv
// lut_neuron_pipe: run-time loadable LUT neuron with a valid/ready inference path
module lut_neuron_pipe
   import lut_neuron_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic             cfg_valid,
   input  logic [OUT_W-1:0] cfg_data,
   output logic             cfg_ready,
   output logic             cfg_done,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             loaded
);
   state_t           state_q, state_d;
   logic [IN_W-1:0]  cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             cfg_done_q, cfg_done_d;
   logic [OUT_W-1:0] rdata;
   logic             we, accept, out_free;

   assign out_free  = !out_valid_q || out_ready;
   assign we        = state_q == LOAD && cfg_valid;
   assign in_ready  = state_q == RUN && !cfg_start && out_free;
   assign accept    = in_valid && in_ready;
   assign cfg_ready = state_q == LOAD;
   assign loaded    = state_q == RUN || state_q == DRAIN;
   assign cfg_done  = cfg_done_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   lut_table_ram #(.IN_W(IN_W), .OUT_W(OUT_W)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (cnt_q),
      .wdata (cfg_data),
      .raddr (in_data),
      .rdata (rdata)
   );

   // cnt wraps to 0 naturally on the last write, so it is 0 on every entry to LOAD
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cfg_done_d = 1'b0;
      case (state_q)
         EMPTY: if (cfg_start) state_d = LOAD;
         LOAD: if (cfg_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (&cnt_q) begin
               state_d    = RUN;
               cfg_done_d = 1'b1;
            end
         end
         RUN:   if (cfg_start) state_d = out_free ? LOAD : DRAIN;
         DRAIN: if (out_free) state_d = LOAD;
         default: state_d = EMPTY;
      endcase
   end

   always_comb begin
      out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
      out_data_d  = accept ? rdata : out_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= EMPTY;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cfg_done_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cfg_done_q  <= cfg_done_d;
      end
   end
endmodule

// File: tb/tb_lut_neuron_pipe.sv
// tb_lut_neuron_pipe: table-driven and directed checks of lut_neuron_pipe
module tb_lut_neuron_pipe;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_start, cfg_valid, cfg_ready, cfg_done;
   logic [1:0] cfg_data;
   logic       in_valid, in_ready, out_valid, out_ready, loaded;
   logic [3:0] in_data;
   logic [1:0] out_data;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       iv;
      logic [3:0] id;
      logic       ordy;
      logic       rdy;
      logic       ov;
      logic [1:0] od;
   } vec_t;
   vec_t vecs[$];

   logic [1:0] tbl1   [16] = '{0,0,3,3,2,1,3,3,0,0,3,2,1,0,3,3};
   logic [1:0] tbl3   [16] = '{3,3,3,3,3,3,3,3,3,3,3,3,3,3,3,3};
   logic [1:0] tblrev [16] = '{3,3,0,1,2,3,0,0,3,3,1,2,3,3,0,0};
   logic [1:0] ld_tbl [16];

   lut_neuron_pipe #(.IN_W(4), .OUT_W(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .cfg_done  (cfg_done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .loaded    (loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // streams ld_tbl; a stray cfg_start mid-load must not restart it
   task automatic do_load(input bit start);
      if (start) begin
         cfg_start = 1'b1;
         step();
         cfg_start = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
         cfg_valid = 1'b1;
         cfg_data  = ld_tbl[i];
         cfg_start = (i == 5);
         #1;
         chk($sformatf("load%0d_cfg_ready", i), cfg_ready, 1);
         chk($sformatf("load%0d_loaded", i), loaded, 0);
         chk($sformatf("load%0d_cfg_done", i), cfg_done, 0);
         step();
      end
      cfg_valid = 1'b0;
      cfg_start = 1'b0;
      chk("load_done_pulse", cfg_done, 1);
      chk("load_loaded", loaded, 1);
      chk("load_cfg_ready_off", cfg_ready, 0);
      step();
      chk("load_done_clear", cfg_done, 0);
      chk("load_loaded_hold", loaded, 1);
   endtask

   task automatic readback();
      for (int i = 0; i < 16; i++) begin
         in_valid  = 1'b1;
         in_data   = 4'(i);
         out_ready = 1'b1;
         #1;
         chk($sformatf("rb%0d_in_ready", i), in_ready, 1);
         step();
         chk($sformatf("rb%0d_out_valid", i), out_valid, 1);
         chk($sformatf("rb%0d_out_data", i), out_data, ld_tbl[i]);
      end
      in_valid = 1'b0;
      step();
      chk("rb_tail_out_valid", out_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_cfg_ready", cfg_ready, 0);
      chk("rst_cfg_done", cfg_done, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_in_ready", in_ready, 0);
      step(); step();
      rst_n = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd3;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk($sformatf("empty%0d_in_ready", i), in_ready, 0);
         chk($sformatf("empty%0d_out_valid", i), out_valid, 0);
         chk($sformatf("empty%0d_loaded", i), loaded, 0);
      end
      in_valid = 1'b0;

      ld_tbl = tbl1;
      do_load(1'b1);

      for (int i = 0; i < 16; i++)
         vecs.push_back(vec_t'{1'b1, 4'(i), 1'b1, 1'b1, 1'b1, tbl1[i]});
      vecs.push_back(vec_t'{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 2'd3});
      vecs.push_back(vec_t'{1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 2'd1});
      for (int i = 0; i < 4; i++)
         vecs.push_back(vec_t'{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 2'd1});
      vecs.push_back(vec_t'{1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 2'd1});
      vecs.push_back(vec_t'{1'b1, 4'd4, 1'b0, 1'b1, 1'b1, 2'd2});
      vecs.push_back(vec_t'{1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 2'd3});
      vecs.push_back(vec_t'{1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 2'd3});
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid  = vecs[i].iv;
         in_data   = vecs[i].id;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
         step();
         chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
         chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].od);
      end

      // stall an item, then request a reload: must pass through DRAIN
      in_valid = 1'b1; in_data = 4'd5; out_ready = 1'b0;
      step();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_data", out_data, 1);
      in_valid = 1'b0;
      cfg_start = 1'b1;
      #1;
      chk("stall_start_in_ready", in_ready, 0);
      step();
      cfg_start = 1'b0;
      chk("drain_cfg_ready", cfg_ready, 0);
      chk("drain_out_valid", out_valid, 1);
      chk("drain_out_data", out_data, 1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk($sformatf("drain%0d_cfg_ready", i), cfg_ready, 0);
         chk($sformatf("drain%0d_out_data", i), out_data, 1);
         chk($sformatf("drain%0d_in_ready", i), in_ready, 0);
      end
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 4'd2;
      #1;
      chk("drain_rel_in_ready", in_ready, 0);
      step();
      out_ready = 1'b0; in_valid = 1'b0;
      chk("drain_to_load_cfg_ready", cfg_ready, 1);
      chk("drain_to_load_out_valid", out_valid, 0);
      chk("drain_to_load_out_data", out_data, 1);
      ld_tbl = tbl3;
      do_load(1'b0);
      chk("reload_old_item_kept", out_data, 1);
      in_valid = 1'b1; in_data = 4'd0; out_ready = 1'b1;
      #1;
      chk("new_tbl_in_ready", in_ready, 1);
      step();
      chk("new_tbl_out_valid", out_valid, 1);
      chk("new_tbl_out_data", out_data, 3);

      // cfg_start beats a simultaneous in_valid
      cfg_start = 1'b1; in_valid = 1'b1; in_data = 4'd7; out_ready = 1'b1;
      #1;
      chk("sim_in_ready", in_ready, 0);
      step();
      cfg_start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      chk("sim_cfg_ready", cfg_ready, 1);
      chk("sim_out_valid", out_valid, 0);
      chk("sim_out_data", out_data, 3);

      // reset after 7 of 16 writes, then a full reload from address 0
      for (int i = 0; i < 7; i++) begin
         cfg_valid = 1'b1; cfg_data = 2'd2;
         step();
      end
      cfg_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_cfg_ready", cfg_ready, 0);
      chk("midrst_loaded", loaded, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_out_data", out_data, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("midrst_empty_cfg_ready", cfg_ready, 0);
      chk("midrst_empty_loaded", loaded, 0);
      ld_tbl = tblrev;
      do_load(1'b1);
      readback();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
